// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / signed-divide engine.
// Each accepted operation spends WIDTH cycles in RUN, doing one bit per cycle.
// It then spends one cycle in DONE, where valid pulses and result is final.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   one-cycle request, honoured only in IDLE with a legal func
//   func    5'b00010 = MUL (low word of a*b), 5'b00011 = DIV (signed quotient)
//   a, b    operands, captured at acceptance
//   result  final value, registered on the RUN->DONE edge and held afterwards
//   valid   one-cycle completion pulse (DONE state)
//   busy    high throughout RUN and DONE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [4:0] FUNC_MUL = 5'b00010;
  localparam logic [4:0] FUNC_DIV = 5'b00011;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic               is_div_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, bmag_reg;
  // MUL: {high partial product, remaining multiplier bits}.
  // DIV: low half shifts dividend bits out and quotient bits in.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   result_reg;

  logic               legal_func;
  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic               div_ge;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   div_final;

  assign legal_func = (func == FUNC_MUL) || (func == FUNC_DIV);
  assign accept     = (state_reg == IDLE) && start && legal_func;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // One shift-add step; the carry out of the upper half lands in the top bit.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // One restoring-division step. The remainder is always below |b|, so the
  // shifted value fits in WIDTH+1 bits.
  assign rem_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
  assign div_ge    = rem_shift >= {1'b0, bmag_reg};
  assign rem_next  = div_ge ? (rem_shift - {1'b0, bmag_reg}) : rem_shift;
  assign quo_next  = {acc_reg[WIDTH-2:0], div_ge};

  // Final quotient, including the step being taken on the RUN->DONE edge.
  always_comb begin
    div_final = neg_reg ? -quo_next : quo_next;
    if (b_reg == '0) begin
      div_final = '1;
    end else if ((a_reg == MIN_VAL) && (b_reg == '1)) begin
      div_final = MIN_VAL;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      bmag_reg   <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg    <= CW'(WIDTH - 1);
            is_div_reg <= (func == FUNC_DIV);
            neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
            a_reg      <= a;
            b_reg      <= b;
            bmag_reg   <= b_mag;
            acc_reg    <= {{WIDTH{1'b0}}, (func == FUNC_DIV) ? a_mag : b};
            rem_reg    <= '0;
          end
        end
        RUN: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
          if (is_div_reg) begin
            acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], quo_next};
            rem_reg <= rem_next;
          end else begin
            acc_reg <= mul_next;
          end
          if (cnt_reg == '0) begin
            result_reg <= is_div_reg ? div_final : mul_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign valid  = (state_reg == DONE);
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit. Inputs change and outputs are
// sampled on the falling clock edge. Cycle 0 is the cycle in which start is
// driven high.
module tb_muldiv_unit;

  localparam logic [4:0] F_MUL = 5'b00010;
  localparam logic [4:0] F_DIV = 5'b00011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  func;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        valid, busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .a(a), .b(b), .result(result), .valid(valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", tag, obs);
    end
  endtask

  // One isolated operation, observed for cycles 1..40.
  task automatic run_op(input string tag, input logic [4:0] f,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp);
    int vcnt, vcyc, berr;
    logic [31:0] r33;
    vcnt = 0; vcyc = -1; berr = 0; r33 = '0;
    @(negedge clk);
    func = f; a = av; b = bv; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      // Scramble inputs to confirm the operands were latched.
      start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; func = F_MUL;
      if (valid) begin vcnt++; vcyc = k; end
      if (busy !== (k <= 33)) berr++;
      if (k == 33) r33 = result;
    end
    check({tag, " valid_cnt"}, 32'(vcnt), 32'd1);
    check({tag, " valid_cyc"}, 32'(vcyc), 32'd33);
    check({tag, " busy_err"},  32'(berr), 32'd0);
    check({tag, " result"},    r33, exp);
    check({tag, " hold40"},    result, exp);
  endtask

  initial begin
    int vcnt, v1, v2, berr;
    logic [31:0] r33, r67;

    rst = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   32'(busy), 32'd0);
    check("reset valid",  32'(valid), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("mul 7*6",         F_MUL, 32'd7,        32'd6,        32'h0000002A);
    run_op("mul ffff*ffff",   F_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("mul min*2",       F_MUL, 32'h80000000, 32'd2,        32'h00000000);
    run_op("mul 2^16*2^16",   F_MUL, 32'h00010000, 32'h00010000, 32'h00000000);
    run_op("div 100/7",       F_DIV, 32'd100,      32'd7,        32'h0000000E);
    run_op("div -7/2",        F_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_op("div 7/-2",        F_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    run_op("div -8/-2",       F_DIV, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00000004);
    run_op("div 5/0",         F_DIV, 32'd5,        32'd0,        32'hFFFFFFFF);
    run_op("div min/-1",      F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);

    // Starts while busy and in DONE are dropped; start in the first IDLE
    // cycle is accepted.
    vcnt = 0; v1 = -1; v2 = -1; r33 = '0; r67 = '0;
    @(negedge clk);
    func = F_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        if (v1 < 0) v1 = k; else v2 = k;
      end
      if (k == 33) r33 = result;
      if (k == 67) r67 = result;
      start = 1'b0;
      if (k == 10 || k == 33 || k == 34) begin
        func = F_MUL; a = 32'd3; b = 32'd3; start = 1'b1;
      end
    end
    check("b2b valid_cnt",  32'(vcnt), 32'd2);
    check("b2b valid1_cyc", 32'(v1), 32'd33);
    check("b2b result1",    r33, 32'h0000000E);
    check("b2b valid2_cyc", 32'(v2), 32'd67);
    check("b2b result2",    r67, 32'h00000009);

    // Reset in the middle of RUN aborts the operation.
    vcnt = 0;
    @(negedge clk);
    func = F_MUL; a = 32'd7; b = 32'd6; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) vcnt++;
      if (k == 11) begin
        check("rst busy",   32'(busy), 32'd0);
        check("rst result", result, 32'd0);
        rst = 1'b0;
      end
      if (k == 10) rst = 1'b1;
    end
    check("rst no_valid", 32'(vcnt), 32'd0);

    // An illegal func code is ignored.
    vcnt = 0; berr = 0;
    @(negedge clk);
    func = 5'b00000; a = 32'd7; b = 32'd6; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) vcnt++;
      if (busy) berr++;
    end
    check("illegal valid",  32'(vcnt), 32'd0);
    check("illegal busy",   32'(berr), 32'd0);
    check("illegal result", result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
